// File: rtl/matmul_pkg.sv
// Shared constants and sequencer state type for the matmul sequencer,
// its register file and the bench.
package matmul_pkg;

  localparam int MAX_DIM   = 4;
  localparam int BUS_WIDTH = 32;
  localparam int DIM_W     = $clog2(MAX_DIM);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/matmul_sequencer.sv
// Sequences one C = A x B operation on the PE array: clear, feed K operand
// slices, wait for the systolic wavefront to drain, then write N rows of C.
module matmul_sequencer #(
  parameter int MAX_DIM = matmul_pkg::MAX_DIM,
  parameter int DIM_W   = $clog2(MAX_DIM)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DIM_W-1:0] dim_n_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  logic [1:0]       sp_target_i,
  output logic             opnd_rd_en_o,
  output logic [DIM_W-1:0] opnd_k_o,
  output logic             pe_clear_o,
  output logic             pe_valid_o,
  output logic             sp_wr_req_o,
  input  logic             sp_gnt_i,
  output logic [DIM_W-1:0] sp_row_o,
  output logic [1:0]       sp_target_o,
  output logic             busy_o,
  output logic             done_o
);
  import matmul_pkg::*;

  // One extra bit so the drain length N+M-1 never wraps.
  localparam int CNT_W = DIM_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{DIM_W{1'b0}}, 1'b1};

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIM_W-1:0] dim_n_q, dim_n_d;
  logic [DIM_W-1:0] dim_k_q, dim_k_d;
  logic [DIM_W-1:0] dim_m_q, dim_m_d;
  logic [1:0]       tgt_q, tgt_d;
  logic             busy_q;
  logic [CNT_W-1:0] k_last_s, n_last_s, drain_last_s;

  assign k_last_s     = {1'b0, dim_k_q};
  assign n_last_s     = {1'b0, dim_n_q};
  assign drain_last_s = n_last_s + {1'b0, dim_m_q};

  // State, shared counter, latched operation parameters and busy flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      dim_n_q <= {DIM_W{1'b0}};
      dim_k_q <= {DIM_W{1'b0}};
      dim_m_q <= {DIM_W{1'b0}};
      tgt_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dim_n_q <= dim_n_d;
      dim_k_q <= dim_k_d;
      dim_m_q <= dim_m_d;
      tgt_q   <= tgt_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dim_n_d = dim_n_q;
    dim_k_d = dim_k_q;
    dim_m_d = dim_m_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dim_n_d = dim_n_i;
          dim_k_d = dim_k_i;
          dim_m_d = dim_m_i;
          tgt_d   = sp_target_i;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (cnt_q == k_last_s) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == drain_last_s) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WRITE: begin
        // A row only retires when the scratchpad grants it.
        if (!sp_gnt_i) begin
          state_d = ST_WRITE;
        end else if (cnt_q == n_last_s) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state and counter only
  always_comb begin
    opnd_rd_en_o = 1'b0;
    pe_valid_o   = 1'b0;
    opnd_k_o     = {DIM_W{1'b0}};
    pe_clear_o   = 1'b0;
    sp_wr_req_o  = 1'b0;
    sp_row_o     = {DIM_W{1'b0}};
    done_o       = 1'b0;
    case (state_q)
      ST_LOAD: pe_clear_o = 1'b1;
      ST_FEED: begin
        opnd_rd_en_o = 1'b1;
        pe_valid_o   = 1'b1;
        opnd_k_o     = cnt_q[DIM_W-1:0];
      end
      ST_WRITE: begin
        sp_wr_req_o = 1'b1;
        sp_row_o    = cnt_q[DIM_W-1:0];
      end
      ST_DONE: done_o = 1'b1;
      default: pe_clear_o = 1'b0;
    endcase
  end

  assign busy_o      = busy_q;
  assign sp_target_o = tgt_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench: each operation's expected event timeline is derived from
// the dimensions and grant plan, and a monitor checks every observed event.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int DW = DIM_W;
  localparam int EV_CLEAR = 0;
  localparam int EV_FEED  = 1;
  localparam int EV_WRITE = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int kind;
    int cyc;
    int idx;
    int tgt;
  } ev_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] dim_n_i = '0, dim_k_i = '0, dim_m_i = '0;
  logic [1:0]    sp_target_i = 2'd0;
  logic          sp_gnt_i = 1'b1;
  logic          opnd_rd_en_o, pe_clear_o, pe_valid_o, sp_wr_req_o, busy_o, done_o;
  logic [DW-1:0] opnd_k_o, sp_row_o;
  logic [1:0]    sp_target_o;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  int  bfrom = 1;
  int  bto = 0;
  bit  gnt_low[int];
  ev_t exp_q[$];
  bit  prev_stall = 1'b0;
  int  prev_row = 0;

  matmul_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .dim_n_i(dim_n_i), .dim_k_i(dim_k_i), .dim_m_i(dim_m_i),
    .sp_target_i(sp_target_i),
    .opnd_rd_en_o(opnd_rd_en_o), .opnd_k_o(opnd_k_o),
    .pe_clear_o(pe_clear_o), .pe_valid_o(pe_valid_o),
    .sp_wr_req_o(sp_wr_req_o), .sp_gnt_i(sp_gnt_i),
    .sp_row_o(sp_row_o), .sp_target_o(sp_target_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      sp_gnt_i = gnt_low.exists(cyc) ? 1'b0 : 1'b1;
    end
  end

  task automatic push(input int kind, input int c, input int idx, input int tgt);
    ev_t e;
    e.kind = kind; e.cyc = c; e.idx = idx; e.tgt = tgt;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input int idx, input int tgt);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got kind=%0d cyc=%0d idx=%0d tgt=%0d required no event",
               kind, cyc, idx, tgt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.idx != idx || e.tgt != tgt) begin
        failures++;
        $display("FAIL event got kind=%0d cyc=%0d idx=%0d tgt=%0d required kind=%0d cyc=%0d idx=%0d tgt=%0d",
                 kind, cyc, idx, tgt, e.kind, e.cyc, e.idx, e.tgt);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from input/state changes
  always @(negedge clk_i) begin
    if (mon_en) begin
      checks++;
      if (busy_o !== ((cyc >= bfrom) && (cyc <= bto))) begin
        failures++;
        $display("FAIL busy cyc=%0d got %0b required %0b", cyc, busy_o, (cyc >= bfrom) && (cyc <= bto));
      end
      checks++;
      if (pe_valid_o !== opnd_rd_en_o || (!opnd_rd_en_o && opnd_k_o != '0) ||
          (!sp_wr_req_o && sp_row_o != '0)) begin
        failures++;
        $display("FAIL idle_decode cyc=%0d got valid=%0b rd_en=%0b k=%0d req=%0b row=%0d required valid=rd_en and zero idx",
                 cyc, pe_valid_o, opnd_rd_en_o, opnd_k_o, sp_wr_req_o, sp_row_o);
      end
      if (prev_stall) begin
        checks++;
        if (!(sp_wr_req_o === 1'b1 && int'(sp_row_o) == prev_row)) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got req=%0b row=%0d required req=1 row=%0d",
                   cyc, sp_wr_req_o, sp_row_o, prev_row);
        end
      end
      prev_stall = sp_wr_req_o && !sp_gnt_i;
      prev_row   = int'(sp_row_o);
      if (pe_clear_o)              pop_cmp(EV_CLEAR, 0, 0);
      if (opnd_rd_en_o)            pop_cmp(EV_FEED, int'(opnd_k_o), 0);
      if (sp_wr_req_o && sp_gnt_i) pop_cmp(EV_WRITE, int'(sp_row_o), int'(sp_target_o));
      if (done_o)                  pop_cmp(EV_DONE, 0, 0);
    end
  end

  // Reference timeline: LOAD 1, FEED K, DRAIN N+M-1, one WRITE per row plus stalls, DONE 1.
  task automatic run_op(input int n, input int k, input int m, input int tgt,
                        input int s0, input int s1, input int s2, input int s3,
                        input bit pf, input bit pd);
    int stall[4];
    int c0, t, done_c;
    stall = '{s0, s1, s2, s3};
    @(posedge clk_i);
    #1;
    c0 = cyc;
    push(EV_CLEAR, c0 + 1, 0, 0);
    for (int j = 0; j <= k; j++) push(EV_FEED, c0 + 2 + j, j, 0);
    t = c0 + 1 + (k + 1) + (n + 1) + (m + 1);
    for (int r = 0; r <= n; r++) begin
      for (int s = 0; s < stall[r]; s++) gnt_low[t + s] = 1'b1;
      t = t + stall[r];
      push(EV_WRITE, t, r, tgt);
      t = t + 1;
    end
    push(EV_DONE, t, 0, 0);
    done_c = t;
    bfrom = c0 + 1;
    bto   = done_c;
    start_i = 1'b1;
    dim_n_i = DW'(n); dim_k_i = DW'(k); dim_m_i = DW'(m);
    sp_target_i = 2'(tgt);
    while (cyc <= done_c) begin
      @(posedge clk_i);
      #1;
      start_i = (pf && cyc == c0 + 2) || (pd && cyc == done_c);
      dim_n_i = (pf && cyc == c0 + 2) ? '0 : DW'($urandom);
      dim_k_i = DW'($urandom);
      dim_m_i = DW'($urandom);
      sp_target_i = 2'($urandom);
    end
    start_i = 1'b0;
    checks++;
    if (sp_target_o !== 2'(tgt)) begin
      failures++;
      $display("FAIL target_hold got %0d required %0d", sp_target_o, tgt);
    end
  endtask

  task automatic run_reset_in_drain();
    int c0;
    @(posedge clk_i);
    #1;
    c0 = cyc;
    push(EV_CLEAR, c0 + 1, 0, 0);
    for (int j = 0; j < 4; j++) push(EV_FEED, c0 + 2 + j, j, 0);
    bfrom = c0 + 1;
    bto   = c0 + 7;
    start_i = 1'b1;
    dim_n_i = DW'(3); dim_k_i = DW'(3); dim_m_i = DW'(3);
    sp_target_i = 2'd2;
    while (cyc < c0 + 7) begin
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checks++;
    if ({busy_o, done_o, sp_wr_req_o, pe_clear_o, opnd_rd_en_o, pe_valid_o,
         sp_target_o, sp_row_o, opnd_k_o} !== '0) begin
      failures++;
      $display("FAIL reset_abort got busy=%0b done=%0b req=%0b tgt=%0d required all zero",
               busy_o, done_o, sp_wr_req_o, sp_target_o);
    end
    repeat (12) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    mon_en = 1'b1;
    checks++;
    if ({busy_o, done_o, sp_wr_req_o, pe_clear_o, opnd_rd_en_o, pe_valid_o,
         sp_target_o, sp_row_o, opnd_k_o} !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%0b done=%0b req=%0b clr=%0b tgt=%0d required all zero",
               busy_o, done_o, sp_wr_req_o, pe_clear_o, sp_target_o);
    end

    run_op(3, 3, 3, 1, 0, 0, 0, 0, 1'b0, 1'b0);
    run_op(0, 0, 0, 2, 0, 0, 0, 0, 1'b0, 1'b0);
    run_op(3, 3, 3, 3, 0, 0, 3, 0, 1'b0, 1'b0);
    run_op(3, 3, 3, 1, 0, 0, 0, 0, 1'b1, 1'b0);
    run_op(2, 1, 3, 2, 0, 0, 0, 0, 1'b0, 1'b1);

    run_reset_in_drain();
    run_op(3, 3, 3, 3, 0, 1, 0, 0, 1'b0, 1'b0);

    // Reset wins over a simultaneous start in IDLE.
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    start_i = 1'b1;
    sp_target_i = 2'd3;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || sp_target_o !== 2'd0 || pe_clear_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_over_start got busy=%0b tgt=%0d clr=%0b required 0 0 0",
               busy_o, sp_target_o, pe_clear_o);
    end
    repeat (3) @(posedge clk_i);

    for (int i = 0; i < 24; i++) begin
      run_op($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    repeat (4) @(posedge clk_i);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter MAX_DIM, default matmul_pkg::MAX_DIM (4); maximum matrix dimension supported by the PE array.
REQ-002 Parameter DIM_W, default $clog2(MAX_DIM) (2); width of every dimension and index field; dimensions are encoded as value-1.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  start request, driven from the CONTROL register start bit.
REQ-006 dim_n_i / dim_k_i / dim_m_i  input  DIM_W each  encoded N (rows of A), K (cols of A / rows of B), M (cols of B).
REQ-007 sp_target_i  input  2  scratchpad slot that receives matrix C.
REQ-008 opnd_rd_en_o  output  1  operand buffers present A column k / B row k to the array this cycle.
REQ-009 opnd_k_o  output  DIM_W  current k index.
REQ-010 pe_clear_o  output  1  clears all PE accumulators.
REQ-011 pe_valid_o  output  1  operand data entering the array is valid.
REQ-012 sp_wr_req_o  output  1  request to write one C row to the scratchpad.
REQ-013 sp_gnt_i  input  1  scratchpad grant; the row is written in any cycle where sp_wr_req_o and sp_gnt_i are both 1.
REQ-014 sp_row_o  output  DIM_W  C row index being written.
REQ-015 sp_target_o  output  2  latched target slot.
REQ-016 busy_o  output  1  high whenever state is not IDLE.
REQ-017 done_o  output  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, FEED, DRAIN, WRITE and DONE, held in a registered state variable.
REQ-019 In IDLE, start_i=1 SHALL latch dim_n_i, dim_k_i, dim_m_i and sp_target_i and move to LOAD; start_i in any other state SHALL be ignored and latched values SHALL stay unchanged.
REQ-020 LOAD SHALL last 1 cycle with pe_clear_o=1, then go to FEED with k counter=0.
REQ-021 FEED SHALL last K cycles with opnd_rd_en_o=1, pe_valid_o=1 and opnd_k_o=k for k=0..K-1, then go to DRAIN.
REQ-022 DRAIN SHALL last N+M-1 cycles (encoded dim_n+dim_m+1) with every datapath output at 0, then go to WRITE with row counter=0.
REQ-023 In WRITE, sp_wr_req_o SHALL be 1 with sp_row_o=row; the row SHALL advance only on a cycle with sp_gnt_i=1, and it SHALL advance from N-1 to DONE.
REQ-024 With sp_gnt_i=0, WRITE SHALL hold, and sp_row_o and sp_wr_req_o SHALL stay stable, for any number of cycles.
REQ-025 DONE SHALL last 1 cycle with done_o=1, then return to IDLE; start_i sampled in DONE SHALL be ignored.
REQ-026 All counters SHALL be DIM_W+1 bits wide so that N+M-1 up to 2*MAX_DIM-1 fits with no wrap-around.
REQ-027 busy_o SHALL be registered; outputs SHALL be pure decodes of registered state and counters, with no combinational path from any input to any output.
REQ-028 sp_target_o SHALL show the latched value from start acceptance until the next accepted start.
REQ-029 With sp_gnt_i held 1, done_o SHALL be asserted exactly K+N+M+N+1 cycles after the cycle in which start_i is sampled.

Reset
REQ-030 rst_i=1 at a clock edge SHALL force IDLE, clear all counters and latched dimensions, and set every output to 0, including sp_target_o.
REQ-031 Reset in mid-operation SHALL abort the operation with no done_o pulse; a row already being requested SHALL be dropped and no further sp_wr_req_o SHALL be raised.
REQ-032 rst_i SHALL take priority over start_i in the same cycle.

Structure
REQ-033 matmul_pkg SHALL hold MAX_DIM, BUS_WIDTH, DIM_W and the sequencer state enum typedef, shared with the register file and the bench.
REQ-034 The block SHALL be a single module with no sub-module; the counters SHALL be inline registers.

Verification
REQ-035 N=K=M=4 (encoded 3,3,3), gnt=1, start at cycle 0 -> LOAD cycle 1, FEED cycles 2-5 with k=0..3, DRAIN 6-12, writes of rows 0..3 in cycles 13-16, done_o in cycle 17 only.
REQ-036 N=K=M=1 (encoded 0), gnt=1 -> pe_clear_o in cycle 1, FEED in cycle 2, DRAIN in cycle 3, row 0 written in cycle 4, done_o in cycle 5.
REQ-037 4x4x4 with sp_gnt_i=0 for 3 cycles on row 2 -> sp_row_o=2 stable for 4 cycles, done_o delayed by exactly 3 cycles (cycle 20).
REQ-038 start_i pulsed during FEED with dim_n_i=0 -> ignored, timing still that of the original 4x4x4 operation, sp_target_o unchanged.
REQ-039 rst_i for 1 cycle during DRAIN -> next cycle busy_o=0 and all outputs 0; no done_o pulse, no sp_wr_req_o; a new start then completes normally.
REQ-040 start_i and rst_i both high in IDLE -> stays in IDLE, busy_o=0.
